johnson_decoder_8bit: RTL and testbench

//  Receive end of the 8-bit Johnson counter bus: samples a Johnson-coded word, checks it is a

---
 rtl/johnson_pkg.sv | 15 +
 rtl/johnson_code_classify.sv | 30 +++
 rtl/johnson_decoder_8bit.sv | 99 +++++++++
 tb/tb_johnson_decoder_8bit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: shared constants, FSM encoding and successor helper for the Johnson receive path.
package johnson_pkg;
    localparam int WIDTH  = 8;
    localparam int STATES = 2 * WIDTH;
    localparam int IDX_W  = $clog2(STATES);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(STATES - 1)) ? '0 : k + IDX_W'(1);
    endfunction
endpackage

// File: rtl/johnson_code_classify.sv
// johnson_code_classify: combinational legality check and state-index decode of a Johnson word.
module johnson_code_classify
    import johnson_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int IW = $clog2(2 * W)
) (
    input  logic [W-1:0]  i_q,
    output logic          o_legal,
    output logic [IW-1:0] o_idx
);
    logic [IW:0]  w_pop;
    logic [W-1:0] w_inv;
    logic         w_low_run;
    logic         w_high_run;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) w_pop = w_pop + (IW+1)'(i_q[i]);
    end

    // A run of ones anchored at bit 0 turns into a single carry when incremented.
    assign w_inv      = ~i_q;
    assign w_low_run  = (i_q & (i_q + W'(1))) == '0;
    assign w_high_run = (w_inv & (w_inv + W'(1))) == '0;
    assign o_legal    = w_low_run | w_high_run;
    assign o_idx      = (i_q == '0) ? '0 :
                        i_q[0]      ? IW'(w_pop) :
                                      IW'((IW+1)'(2 * W) - w_pop);
endmodule

// File: rtl/johnson_decoder_8bit.sv
// johnson_decoder_8bit: checks, decodes and sequence-tracks sampled Johnson words.
// Optional saturating error tally enabled by defining JOHNSON_DEC_ERRCNT_EN.
module johnson_decoder_8bit
    import johnson_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_valid,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             wrap,
    output logic             locked,
    output logic [7:0]       err_count
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_index;
    logic             r_index_valid;
    logic             r_illegal;
    logic             r_seq_err;
    logic             r_wrap;
    logic             w_legal;
    logic [IDX_W-1:0] w_idx;
    logic             w_good;
    logic             w_bad;
    logic             w_succ;
    logic             w_seq_err_nxt;
    logic             w_wrap_nxt;

    johnson_code_classify #(.W(WIDTH), .IW(IDX_W)) u_classify (
        .i_q    (q_in),
        .o_legal(w_legal),
        .o_idx  (w_idx)
    );

    assign w_good = q_valid & w_legal;
    assign w_bad  = q_valid & ~w_legal;
    assign w_succ = w_idx == next_idx(r_index);

    // The index register doubles as the reference for the sequence check.
    always_comb begin
        w_state_nxt   = r_state;
        w_seq_err_nxt = 1'b0;
        w_wrap_nxt    = 1'b0;
        case (r_state)
            ST_UNLOCKED: if (w_good) w_state_nxt = ST_LOCKED;
            ST_LOCKED: begin
                if (w_bad) w_state_nxt = ST_UNLOCKED;
                w_seq_err_nxt = w_good & (w_idx != r_index) & ~w_succ;
                w_wrap_nxt    = w_good & w_succ & (r_index == IDX_W'(STATES - 1));
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_UNLOCKED;
            r_index       <= '0;
            r_index_valid <= 1'b0;
            r_illegal     <= 1'b0;
            r_seq_err     <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_index       <= w_good ? w_idx : r_index;
            r_index_valid <= w_good;
            r_illegal     <= w_bad;
            r_seq_err     <= w_seq_err_nxt;
            r_wrap        <= w_wrap_nxt;
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic       w_err;

    assign w_err = w_bad | w_seq_err_nxt;

    always_ff @(posedge clk) begin
        if (!rst) r_err_cnt <= '0;
        else      r_err_cnt <= (w_err && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

    assign index       = r_index;
    assign index_valid = r_index_valid;
    assign illegal     = r_illegal;
    assign seq_err     = r_seq_err;
    assign wrap        = r_wrap;
    assign locked      = r_state == ST_LOCKED;
endmodule

// File: tb/tb_johnson_decoder_8bit.sv
// tb_johnson_decoder_8bit: directed scenarios plus random traffic against a table-driven model.
module tb_johnson_decoder_8bit;
    logic       clk;
    logic       rst;
    logic [7:0] q_in;
    logic       q_valid;
    logic [3:0] index;
    logic       index_valid;
    logic       illegal;
    logic       seq_err;
    logic       wrap;
    logic       locked;
    logic [7:0] err_count;

    johnson_decoder_8bit dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .q_valid    (q_valid),
        .index      (index),
        .index_valid(index_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .wrap       (wrap),
        .locked     (locked),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] code [16];
    int  m_ref, m_lock, m_errs;
    int  m_idx, m_iv, m_il, m_se, m_wr;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_code(input logic [7:0] q);
        for (int k = 0; k < 16; k++) if (code[k] == q) return k;
        return -1;
    endfunction

    task automatic model(input logic r, input logic v, input logic [7:0] q);
        int k;
        m_iv = 0; m_il = 0; m_se = 0; m_wr = 0;
        if (!r) begin
            m_ref = 0; m_lock = 0; m_errs = 0;
        end else begin
            if (v) begin
                k = find_code(q);
                if (k >= 0) begin
                    m_iv = 1;
                    if (m_lock != 0) begin
                        m_se = (k != m_ref && k != (m_ref + 1) % 16) ? 1 : 0;
                        m_wr = (m_ref == 15 && k == 0) ? 1 : 0;
                    end
                    m_ref = k;
                    m_lock = 1;
                end else begin
                    m_il = 1;
                    m_lock = 0;
                end
            end
            if ((m_il | m_se) != 0 && m_errs < 255) m_errs++;
        end
        m_idx = m_ref;
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] q);
        rst = r; q_valid = v; q_in = q;
        @(posedge clk);
        model(r, v, q);
        #1;
        check("index", index, m_idx);
        check("index_valid", index_valid, m_iv);
        check("illegal", illegal, m_il);
        check("seq_err", seq_err, m_se);
        check("wrap", wrap, m_wr);
        check("locked", locked, m_lock);
`ifdef JOHNSON_DEC_ERRCNT_EN
        check("err_count", err_count, m_errs);
`else
        check("err_count", err_count, 0);
`endif
    endtask

    initial begin
        int k;
        logic [7:0] q;
        for (int i = 0; i <= 8; i++) code[i] = 8'((1 << i) - 1);
        for (int i = 9; i < 16; i++) code[i] = 8'(8'hFF << (i - 8));
        m_ref = 0; m_lock = 0; m_errs = 0;
        rst = 1'b0; q_valid = 1'b0; q_in = 8'h00;

        cyc(0, 0, 8'h00);
        check("reset_index", index, 0);
        check("reset_locked", locked, 0);

        for (int i = 0; i <= 16; i++) cyc(1, 1, code[i % 16]);
        check("t1_wrap", wrap, 1);
        check("t1_index", index, 0);

        for (int i = 0; i < 5; i++) cyc(1, 1, 8'h07);
        check("t2_index", index, 3);
        check("t2_iv", index_valid, 1);

        cyc(1, 1, 8'h3F);
        cyc(1, 0, 8'h55);
        cyc(1, 1, 8'h55);
        check("t3_illegal", illegal, 1);
        check("t3_locked", locked, 0);
        check("t3_index", index, 6);

        cyc(1, 1, 8'h03);
        cyc(1, 1, 8'h0F);
        check("t4_seq_err", seq_err, 1);
        check("t4_index", index, 4);
        check("t4_locked", locked, 1);

        cyc(0, 1, 8'h1F);
        check("t5_reset_index", index, 0);
        cyc(1, 1, 8'hFC);
        check("t5_index", index, 10);
        check("t5_seq_err", seq_err, 0);

        for (int i = 0; i < 260; i++) cyc(1, 1, (i % 2 == 0) ? 8'h55 : 8'hAA);
`ifdef JOHNSON_DEC_ERRCNT_EN
        check("t6_sat", err_count, 255);
`else
        check("t6_off", err_count, 0);
`endif

        cyc(0, 0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: k = m_ref;
                1: k = (m_ref + 1) % 16;
                2: k = $urandom_range(0, 15);
                default: k = -1;
            endcase
            q = (k < 0) ? 8'($urandom) : code[k];
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
